// File: rtl/multicycle_memory_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_mem_pkg
// Shared types and default sizing for the multicycle backing store.
//   - memState_t   : controller states (IDLE, WAIT, BURST, WRITE)
//   - DEFAULT_*    : default latency, line length and storage depth
//   - LINE_OFF_W   : width of the word offset inside a cache line
//   - lineWordAddr : byte address of a word within the line that holds 'a'
// ----------------------------------------------------------------------------
package multicycle_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        WRITE = 2'd3
    } memState_t;

    localparam int DEFAULT_LATENCY   = 4;
    localparam int DEFAULT_BURST_LEN = 8;
    localparam int DEFAULT_MEM_WORDS = 32768;
    localparam int LINE_OFF_W        = $clog2(DEFAULT_BURST_LEN);

    // Clears the line-offset and byte bits of 'a' and inserts word index
    // 'idx' (taken modulo the line length), so the offset never carries
    // into the line base.
    function automatic logic [15:0] lineWordAddr(input logic [15:0] a,
                                                 input int          offW,
                                                 input int          idx);
        logic [15:0] lowMask;
        logic [15:0] wordOff;
        lowMask = 16'((32'd1 << (offW + 1)) - 32'd1);
        wordOff = 16'((idx & ((32'd1 << offW) - 32'd1)) << 1);
        return (a & ~lowMask) | wordOff;
    endfunction

endpackage

// File: rtl/multicycle_memory_if.sv
// ----------------------------------------------------------------------------
// multicycle_memory_if
// Request / response bundle between the cache-side requester (master) and
// the multicycle backing store (slave).
//   enable, wr, addr, data_in        : request, driven by the master
//   busy, data_valid, data_out, addr_out : status and read stream, driven
//                                          by the slave
// ----------------------------------------------------------------------------
interface multicycle_memory_if;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        busy;
    logic        data_valid;
    logic [15:0] data_out;
    logic [15:0] addr_out;

    modport master (
        output enable, wr, addr, data_in,
        input  busy, data_valid, data_out, addr_out
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output busy, data_valid, data_out, addr_out
    );
endinterface

// File: rtl/multicycle_memory_mem_word_array.sv
// ----------------------------------------------------------------------------
// mem_word_array
// Single-port synchronous word store with registered read, no reset.
//   clk   : clock
//   we    : write enable for 'wdata' at 'addr'
//   addr  : word address (shared by read and write)
//   wdata : write data
//   rdata : word at the address sampled on the previous rising edge
// ----------------------------------------------------------------------------
module mem_word_array #(
    parameter int DEPTH = 32768,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/multicycle_memory.sv
// ----------------------------------------------------------------------------
// multicycle_memory
// Backing store with fixed access latency. A read returns a whole cache line
// as a burst of BURST_LEN words (one per cycle, each tagged with its byte
// address); a write stores one word after LATENCY cycles.
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : multicycle_memory_if.slave (enable/wr/addr/data_in in,
//         busy/data_valid/data_out/addr_out out, all outputs registered)
// Build option: define MULTICYCLE_MEM_CRITICAL_WORD_FIRST_EN to start each
// burst at the requested word instead of the line base.
// ----------------------------------------------------------------------------
module multicycle_memory
    import multicycle_mem_pkg::*;
#(
    parameter int LATENCY   = DEFAULT_LATENCY,
    parameter int BURST_LEN = DEFAULT_BURST_LEN,
    parameter int MEM_WORDS = DEFAULT_MEM_WORDS
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_memory_if.slave  bus
);

    localparam int OFF_W = (BURST_LEN == DEFAULT_BURST_LEN) ? LINE_OFF_W
                                                            : $clog2(BURST_LEN);
    localparam int LAT_W = $clog2(LATENCY + 1);
    localparam int AW    = $clog2(MEM_WORDS);

    memState_t stateReg, stateNext;

    logic [LAT_W-1:0] latCnt;
    logic [OFF_W-1:0] burstCnt;
    logic [OFF_W-1:0] fetchCnt;
    logic [OFF_W-1:0] startReg;
    logic [OFF_W-1:0] startIn;
    logic [15:0]      addrReg;
    logic [15:0]      dataReg;
    logic             busyReg;
    logic             validReg;
    logic [15:0]      dataOutReg;
    logic [15:0]      addrOutReg;

    logic             accept;
    logic             latDone;
    logic             burstDone;
    logic             fetchInc;
    logic             loadOut;
    logic             memWe;
    logic [AW-1:0]    memAddr;
    logic [15:0]      memRdata;
    logic [15:0]      fetchBase;
    logic [OFF_W-1:0] fetchStart;
    logic [15:0]      fetchByteAddr;
    logic [15:0]      nextWordAddr;

`ifdef MULTICYCLE_MEM_CRITICAL_WORD_FIRST_EN
    assign startIn = bus.addr[OFF_W:1];
`else
    assign startIn = '0;
`endif

    assign accept    = (stateReg == IDLE) && bus.enable;
    assign latDone   = (latCnt == LAT_W'(LATENCY - 1));
    assign burstDone = (burstCnt == OFF_W'(BURST_LEN - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (accept)    stateNext = bus.wr ? WRITE : WAIT;
            WAIT:    if (latDone)   stateNext = BURST;
            BURST:   if (burstDone) stateNext = IDLE;
            WRITE:   if (latDone)   stateNext = IDLE;
            default:                stateNext = IDLE;
        endcase
    end

    // Control decode. The array read is registered and data_out registers it
    // again, so word k must be addressed two cycles before it is presented;
    // fetchCnt therefore runs ahead of burstCnt. With LATENCY=1 the first
    // fetch happens in IDLE, straight from the incoming request address.
    always_comb begin
        memWe      = 1'b0;
        fetchInc   = 1'b0;
        loadOut    = 1'b0;
        fetchBase  = addrReg;
        fetchStart = startReg;
        case (stateReg)
            IDLE: begin
                fetchBase  = bus.addr;
                fetchStart = startIn;
                fetchInc   = accept && !bus.wr && (LATENCY == 1);
            end
            WAIT: begin
                fetchInc = (int'(latCnt) + 2 >= LATENCY);
                loadOut  = latDone;
            end
            BURST: begin
                fetchInc = 1'b1;
                loadOut  = !burstDone;
            end
            WRITE: begin
                memWe = latDone;
            end
            default: ;
        endcase

        fetchByteAddr = lineWordAddr(fetchBase, OFF_W,
                                     int'(fetchStart) + int'(fetchCnt));
        nextWordAddr  = lineWordAddr(addrReg, OFF_W,
                                     int'(startReg) +
                                     ((stateReg == BURST) ? int'(burstCnt) + 1 : 0));
        memAddr       = memWe ? AW'(addrReg >> 1) : AW'(fetchByteAddr >> 1);
    end

    // Counters, request latches and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latCnt     <= '0;
            burstCnt   <= '0;
            fetchCnt   <= '0;
            startReg   <= '0;
            addrReg    <= '0;
            dataReg    <= '0;
            busyReg    <= 1'b0;
            validReg   <= 1'b0;
            dataOutReg <= '0;
            addrOutReg <= '0;
        end else begin
            if (accept) begin
                addrReg  <= bus.addr;
                dataReg  <= bus.data_in;
                startReg <= startIn;
                busyReg  <= 1'b1;
                latCnt   <= '0;
            end

            if ((stateReg == WAIT || stateReg == WRITE) && !latDone) begin
                latCnt <= latCnt + 1'b1;
            end

            if (stateNext == IDLE) begin
                fetchCnt <= '0;
            end else if (fetchInc) begin
                fetchCnt <= fetchCnt + 1'b1;
            end

            if (stateReg == WAIT && latDone) begin
                burstCnt <= '0;
            end else if (stateReg == BURST && !burstDone) begin
                burstCnt <= burstCnt + 1'b1;
            end

            if (loadOut) begin
                dataOutReg <= memRdata;
                addrOutReg <= nextWordAddr;
                validReg   <= 1'b1;
            end

            if (stateReg == BURST && burstDone) begin
                validReg <= 1'b0;
                busyReg  <= 1'b0;
            end

            if (stateReg == WRITE && latDone) begin
                busyReg <= 1'b0;
            end
        end
    end

    mem_word_array #(
        .DEPTH (MEM_WORDS),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (memWe),
        .addr  (memAddr),
        .wdata (dataReg),
        .rdata (memRdata)
    );

    assign bus.busy       = busyReg;
    assign bus.data_valid = validReg;
    assign bus.data_out   = dataOutReg;
    assign bus.addr_out   = addrOutReg;

endmodule

// File: doc/multicycle_memory.md
# multicycle_memory

Backing store behind the memory interface that arbitrates instruction-fetch and data requests. It accepts one request at a time, models a fixed multicycle access latency, and streams each read back as a full cache-line burst, one 16-bit word per cycle. Each word carries its address, so the interface can raise the matching cache write enable. Writes are single-word and write-through.

## Interface
- LATENCY, 4, cycles from request acceptance to first read word or write commit; legal range ≥1
- BURST_LEN, 8, words per cache line; power of two
- MEM_WORDS, 32768, storage depth in 16-bit words (covers the 16-bit byte address space)
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- enable  input  1  request strobe; sampled only when busy is low
- wr  input  1  1 = write one word, 0 = read one line
- addr  input  16  byte address; bit 0 ignored
- data_in  input  16  write data
- busy  output  1  request in progress; new requests ignored
- data_valid  output  1  data_out/addr_out hold a read word this cycle
- data_out  output  16  read word
- addr_out  output  16  byte address of data_out

## Operation
- Registered FSM states: IDLE, WAIT, BURST, WRITE.
- IDLE: on a rising edge with enable=1 and busy=0, the block latches wr, addr and data_in.
  - wr=1: go to WRITE.
  - wr=0: go to WAIT.
- WAIT: count LATENCY cycles, then go to BURST.
- BURST: emit BURST_LEN words with consecutive data_valid, then return to IDLE.
- WRITE: count LATENCY cycles. At the final edge, write the array at addr[15:1] and return to IDLE.
- Line base = addr with bits [log2(BURST_LEN):0] cleared (0xFFF0 for the defaults).
- Word k address = line base + 2·((start_offset + k) mod BURST_LEN). start_offset is 0 unless the configuration macro is enabled.
- Address arithmetic is 16-bit. The word offset wraps within the line and never carries into the line base.
- enable while busy=1 is ignored entirely; the requester must hold the request until it is accepted.
- A read that follows a write to the same word returns the new data, because the write commits before busy falls.
- Reset values, applied asynchronously: state=IDLE, counters=0, busy=0, data_valid=0, data_out=0x0000, addr_out=0x0000.
- Array contents are not cleared by reset.
- Reset mid-burst or mid-write aborts the request immediately. An uncommitted write is discarded.

## Timing
- Cycle n is the interval after edge En. E0 is the accepting edge.
- Read:
  - busy=1 in cycles 0 through LATENCY+BURST_LEN−1.
  - data_valid=1 in cycles LATENCY through LATENCY+BURST_LEN−1.
  - Word k is presented in cycle LATENCY+k.
  - busy=0 in cycle LATENCY+BURST_LEN, so the earliest next acceptance is edge E(LATENCY+BURST_LEN).
- Write:
  - busy=1 in cycles 0 through LATENCY−1.
  - Array updated at edge E(LATENCY); busy=0 in cycle LATENCY.
- data_valid is never asserted for writes.
- data_out and addr_out hold their last values when data_valid=0.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- MULTICYCLE_MEM_CRITICAL_WORD_FIRST_EN
  - Defined: start_offset = addr[log2(BURST_LEN):1]. The burst begins with the requested word and wraps to the line base.
  - Undefined: start_offset = 0. The burst always begins at the line base.
- Latency, burst length and busy window are identical in both builds.

## Structure
- Package multicycle_mem_pkg holds:
  - the state enum (IDLE, WAIT, BURST, WRITE)
  - default LATENCY, BURST_LEN and MEM_WORDS
  - the line offset width constant, log2(BURST_LEN)
- Sub-module mem_word_array: a synchronous single-port word array with a 16-bit read/write port and no reset. It is instantiated once.
- The FSM, latency counter, burst counter and output registers live in the top level.

## Test plan
- Reset, then idle 5 cycles → busy=0, data_valid=0, data_out=0x0000, addr_out=0x0000.
- Write 0xBEEF at 0x0024, wait for busy to fall, then read 0x0020 → busy high cycles 0–11. data_valid in cycles 4–11. Word at cycle 6 has addr_out=0x0024, data_out=0xBEEF.
- Critical word first: read 0x002A.
  - Macro defined → addr_out sequence 0x2A, 0x2C, 0x2E, 0x20 … 0x28.
  - Macro undefined → sequence 0x20 through 0x2E.
- Assert enable with wr=1 at 0x0010 during a read burst → request ignored. After busy falls, 0x0010 still holds its old value.
- Write 0x1234 at 0x0004, then assert rst at cycle 2 → outputs reset immediately. A subsequent read of 0x0004 returns the prior value.
- Address 0xFFF8 read → line base 0xFFF0, last addr_out 0xFFFE. No wrap to 0x0000.
